// File: rtl/div_ctrl_pkg.sv
// Shared constants for the divider mode sequencer: state encoding, mode
// width, the highest mode value and the mode-advance helper.
package div_ctrl_pkg;

    localparam int MODE_W = 2;

    typedef logic [MODE_W-1:0] mode_t;
    typedef logic [1:0]        state_t;

    localparam mode_t  MODE_MAX = 2'd3;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_DWELL = 2'd1;
    localparam state_t ST_PEND  = 2'd2;

    // Next mode in the auto sequence; the highest mode wraps back to 0.
    function automatic mode_t next_mode(input mode_t cur);
        mode_t nxt;
        if (cur == MODE_MAX) begin
            nxt = 2'd0;
        end else begin
            nxt = cur + 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/div_edge_wait.sv
// Waits for a rising edge of the divided clock while armed. A switch fires
// on the edge that samples div_out high after a low sample, or is forced
// once TMO_CYC armed cycles have gone by without such an edge.
module div_edge_wait #(
    parameter int TMO_CYC = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic arm,
    input  logic div_out,
    output logic fire,
    output logic forced
);

    // Counter holds the number of armed cycles already completed (0..TMO_CYC-1).
    localparam int CNT_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYC - 1);

    logic             r_div_q;
    logic [CNT_W-1:0] r_wait_cnt;
    logic             w_rise;
    logic             w_expired;

    assign w_rise    = div_out & ~r_div_q;
    assign w_expired = (r_wait_cnt == TMO_LAST);
    assign fire      = arm & (w_rise | w_expired);
    assign forced    = arm & ~w_rise & w_expired;

    // Previous div_out sample; cleared by reset so the first detect after release sees 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_q <= 1'b0;
        end else begin
            r_div_q <= div_out;
        end
    end

    // Armed-cycle counter; restarts whenever the wait ends or is not armed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (arm && !fire) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1'b1);
        end else begin
            r_wait_cnt <= '0;
        end
    end

endmodule

// File: rtl/div_mode_sequencer.sv
// Mode sequencer for a 4-mode clock divider. Steps the mode automatically
// after a programmable dwell or on manual request, and always applies a new
// mode on a rising edge of the divided clock (or after a bounded wait).
module div_mode_sequencer
    import div_ctrl_pkg::*;
#(
    parameter int DWELL_W = 16,
    parameter int TMO_CYC = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               auto_en,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               req_valid,
    input  logic [MODE_W-1:0]  req_mode,
    output logic               req_ready,
    input  logic               div_out,
    output logic [MODE_W-1:0]  mode,
    output logic               busy,
    output logic               switch_done,
    output logic               timeout
);

    localparam logic [DWELL_W-1:0] CNT_ONE = DWELL_W'(1'b1);

    // A dwell of 0 would never reach the switch point, so it counts as 1.
    function automatic logic [DWELL_W-1:0] dwell_load(input logic [DWELL_W-1:0] d);
        logic [DWELL_W-1:0] v;
        if (d == '0) begin
            v = CNT_ONE;
        end else begin
            v = d;
        end
        return v;
    endfunction

    state_t             r_state;
    mode_t              r_mode;
    mode_t              r_target;
    logic [DWELL_W-1:0] r_cnt;
    logic               r_auto;
    logic               r_stop_pend;
    logic               r_busy;
    logic               r_req_ready;
    logic               r_switch_done;
    logic               r_timeout;

    state_t             w_state_nx;
    mode_t              w_mode_nx;
    mode_t              w_target_nx;
    logic [DWELL_W-1:0] w_cnt_nx;
    logic               w_auto_nx;
    logic               w_stop_pend_nx;
    logic               w_done_nx;
    logic               w_timeout_nx;
    logic               w_arm;
    logic               w_fire;
    logic               w_forced;

    assign w_arm = (r_state == ST_PEND);

    div_edge_wait #(
        .TMO_CYC (TMO_CYC)
    ) u_edge_wait (
        .clk     (clk),
        .rst_n   (rst_n),
        .arm     (w_arm),
        .div_out (div_out),
        .fire    (w_fire),
        .forced  (w_forced)
    );

    // Next-state and next-output decode for the IDLE / DWELL / PEND sequencer.
    always_comb begin
        w_state_nx     = r_state;
        w_mode_nx      = r_mode;
        w_target_nx    = r_target;
        w_cnt_nx       = r_cnt;
        w_auto_nx      = r_auto;
        w_stop_pend_nx = r_stop_pend;
        w_done_nx      = 1'b0;
        w_timeout_nx   = r_timeout;
        case (r_state)
            ST_IDLE: begin
                // A manual request outranks start; start+stop together is a stop.
                if (req_valid && r_req_ready) begin
                    w_target_nx    = req_mode;
                    w_auto_nx      = 1'b0;
                    w_stop_pend_nx = 1'b0;
                    w_state_nx     = ST_PEND;
                end else if (start && auto_en && !stop) begin
                    w_cnt_nx       = dwell_load(dwell);
                    w_auto_nx      = 1'b1;
                    w_stop_pend_nx = 1'b0;
                    w_timeout_nx   = 1'b0;
                    w_state_nx     = ST_DWELL;
                end else begin
                    w_state_nx     = ST_IDLE;
                end
            end
            ST_DWELL: begin
                if (stop) begin
                    w_auto_nx  = 1'b0;
                    w_cnt_nx   = '0;
                    w_state_nx = ST_IDLE;
                end else if (r_cnt == CNT_ONE) begin
                    w_target_nx = next_mode(r_mode);
                    w_cnt_nx    = '0;
                    w_state_nx  = ST_PEND;
                end else begin
                    w_cnt_nx    = r_cnt - CNT_ONE;
                end
            end
            ST_PEND: begin
                if (w_fire) begin
                    w_mode_nx = r_target;
                    w_done_nx = 1'b1;
                    if (w_forced) begin
                        w_timeout_nx = 1'b1;
                    end else begin
                        w_timeout_nx = r_timeout;
                    end
                    // An auto session keeps cycling unless a stop arrived while pending.
                    if (r_auto && !r_stop_pend && !stop) begin
                        w_cnt_nx   = dwell_load(dwell);
                        w_state_nx = ST_DWELL;
                    end else begin
                        w_auto_nx      = 1'b0;
                        w_stop_pend_nx = 1'b0;
                        w_state_nx     = ST_IDLE;
                    end
                end else if (stop) begin
                    w_stop_pend_nx = 1'b1;
                end else begin
                    w_stop_pend_nx = r_stop_pend;
                end
            end
            default: begin
                w_auto_nx      = 1'b0;
                w_stop_pend_nx = 1'b0;
                w_cnt_nx       = '0;
                w_state_nx     = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs; busy/req_ready follow the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_mode        <= 2'd0;
            r_target      <= 2'd0;
            r_cnt         <= '0;
            r_auto        <= 1'b0;
            r_stop_pend   <= 1'b0;
            r_busy        <= 1'b0;
            r_req_ready   <= 1'b1;
            r_switch_done <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_mode        <= w_mode_nx;
            r_target      <= w_target_nx;
            r_cnt         <= w_cnt_nx;
            r_auto        <= w_auto_nx;
            r_stop_pend   <= w_stop_pend_nx;
            r_busy        <= (w_state_nx != ST_IDLE);
            r_req_ready   <= (w_state_nx == ST_IDLE);
            r_switch_done <= w_done_nx;
            r_timeout     <= w_timeout_nx;
        end
    end

    assign mode        = r_mode;
    assign busy        = r_busy;
    assign req_ready   = r_req_ready;
    assign switch_done = r_switch_done;
    assign timeout     = r_timeout;

endmodule

// File: tb/tb_div_mode_sequencer.sv
// Directed self-checking bench for div_mode_sequencer.
module tb_div_mode_sequencer;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic        start     = 1'b0;
    logic        stop      = 1'b0;
    logic        auto_en   = 1'b0;
    logic [15:0] dwell     = 16'd0;
    logic        req_valid = 1'b0;
    logic [1:0]  req_mode  = 2'd0;
    logic        div_out   = 1'b0;
    logic        req_ready;
    logic [1:0]  mode;
    logic        busy;
    logic        switch_done;
    logic        timeout;

    int          n_pass = 0;
    int          n_chk  = 0;
    int          cyc    = 0;
    logic        gen_en = 1'b0;
    logic [2:0]  ph     = 3'd0;

    div_mode_sequencer #(
        .DWELL_W (16),
        .TMO_CYC (255)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .auto_en     (auto_en),
        .dwell       (dwell),
        .req_valid   (req_valid),
        .req_mode    (req_mode),
        .req_ready   (req_ready),
        .div_out     (div_out),
        .mode        (mode),
        .busy        (busy),
        .switch_done (switch_done),
        .timeout     (timeout)
    );

    // 10 ns system clock.
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock; inputs change and outputs are sampled 1 ns after the edge.
    // When enabled, div_out is a divide-by-8 square wave (4 low, 4 high).
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (gen_en) begin
            ph      = ph + 3'd1;
            div_out = ph[2];
        end
    endtask

    logic [1:0] exp_seq [4] = '{2'd1, 2'd2, 2'd3, 2'd0};

    initial begin
        int pulses;
        int last;
        int gap;
        int done_cnt;

        // ---- reset state ----
        #1 rst_n = 1'b0;
        #2;
        check_eq("rst_mode", mode, 2'd0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_ready", req_ready, 1'b1);
        check_eq("rst_done", switch_done, 1'b0);
        check_eq("rst_tmo", timeout, 1'b0);
        tick();
        tick();
        check_eq("rst_hold_busy", busy, 1'b0);
        rst_n = 1'b1;
        tick();

        // ---- edge alignment; start+req_valid together takes the manual path ----
        dwell = 16'd100; auto_en = 1'b1; start = 1'b1;
        req_valid = 1'b1; req_mode = 2'd2;
        tick();
        start = 1'b0; req_mode = 2'd1;   // request while busy must be refused
        check_eq("edge_busy", busy, 1'b1);
        check_eq("edge_ready_busy", req_ready, 1'b0);
        tick();
        req_valid = 1'b0;
        check_eq("edge_ready_busy2", req_ready, 1'b0);
        repeat (9) tick();
        check_eq("edge_mode_wait", mode, 2'd0);
        div_out = 1'b1;
        tick();
        check_eq("edge_mode_sw", mode, 2'd2);
        check_eq("edge_done", switch_done, 1'b1);
        check_eq("edge_idle", busy, 1'b0);
        check_eq("edge_tmo", timeout, 1'b0);
        div_out = 1'b0;
        tick();
        check_eq("edge_done_clr", switch_done, 1'b0);
        check_eq("edge_ready", req_ready, 1'b1);
        check_eq("edge_mode_keep", mode, 2'd2);

        // ---- forced switch after 255 cycles with div_out stuck low ----
        req_valid = 1'b1; req_mode = 2'd3;
        tick();
        req_valid = 1'b0;
        repeat (254) tick();
        check_eq("tmo_mode_wait", mode, 2'd2);
        check_eq("tmo_busy_wait", busy, 1'b1);
        check_eq("tmo_flag_wait", timeout, 1'b0);
        tick();
        check_eq("tmo_mode", mode, 2'd3);
        check_eq("tmo_flag", timeout, 1'b1);
        check_eq("tmo_done", switch_done, 1'b1);
        check_eq("tmo_idle", busy, 1'b0);
        repeat (3) tick();
        check_eq("tmo_sticky", timeout, 1'b1);

        // ---- boundaries: ignored starts, dwell=0, wrap 3->0 ----
        auto_en = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("noauto_busy", busy, 1'b0);
        check_eq("noauto_tmo", timeout, 1'b1);
        auto_en = 1'b1; start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check_eq("ststop_busy", busy, 1'b0);
        check_eq("ststop_ready", req_ready, 1'b1);
        check_eq("ststop_tmo", timeout, 1'b1);
        dwell = 16'd0; start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("d0_busy", busy, 1'b1);
        check_eq("d0_tmo_clr", timeout, 1'b0);
        tick();
        check_eq("d0_mode_wait", mode, 2'd3);
        div_out = 1'b1;
        tick();
        check_eq("d0_wrap", mode, 2'd0);
        check_eq("d0_done", switch_done, 1'b1);
        check_eq("d0_reload", busy, 1'b1);
        div_out = 1'b0; stop = 1'b1;
        tick();
        stop = 1'b0;
        check_eq("d0_stop_idle", busy, 1'b0);
        check_eq("d0_stop_mode", mode, 2'd0);

        // ---- auto run 0,1,2,3,0 with dwell=100 ----
        dwell = 16'd100; ph = 3'd0; div_out = 1'b0; gen_en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("auto_busy", busy, 1'b1);
        pulses = 0;
        last   = cyc;
        for (int i = 0; i < 1000 && pulses < 4; i++) begin
            tick();
            if (switch_done) begin
                gap = cyc - last;
                check_eq("auto_mode", mode, exp_seq[pulses]);
                check_eq("auto_gap_min", (gap >= 101), 1'b1);
                check_eq("auto_gap_max", (gap <= 109), 1'b1);
                last = cyc;
                pulses++;
            end
        end
        check_eq("auto_pulses", pulses, 4);
        gen_en = 1'b0; div_out = 1'b0; stop = 1'b1;
        tick();
        stop = 1'b0;
        check_eq("auto_stop_idle", busy, 1'b0);
        check_eq("auto_stop_mode", mode, 2'd0);
        check_eq("auto_tmo", timeout, 1'b0);

        // ---- stop in DWELL with counter at 50 ----
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (50) tick();
        check_eq("s50_busy", busy, 1'b1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_eq("s50_idle", busy, 1'b0);
        check_eq("s50_mode", mode, 2'd0);
        check_eq("s50_done", switch_done, 1'b0);

        // ---- stop in PEND completes the switch, then IDLE ----
        dwell = 16'd2; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check_eq("sp_pend_busy", busy, 1'b1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_eq("sp_still_pend", busy, 1'b1);
        check_eq("sp_mode_wait", mode, 2'd0);
        div_out = 1'b1;
        tick();
        check_eq("sp_mode", mode, 2'd1);
        check_eq("sp_done", switch_done, 1'b1);
        check_eq("sp_idle", busy, 1'b0);
        div_out = 1'b0;
        tick();
        check_eq("sp_done_clr", switch_done, 1'b0);
        check_eq("sp_stay_idle", busy, 1'b0);

        // ---- reset in the middle of PEND ----
        req_valid = 1'b1; req_mode = 2'd2;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        check_eq("rp_busy", busy, 1'b1);
        rst_n = 1'b0;
        #2;
        check_eq("rp_mode", mode, 2'd0);
        check_eq("rp_busy_clr", busy, 1'b0);
        check_eq("rp_ready", req_ready, 1'b1);
        #2;
        rst_n   = 1'b1;
        div_out = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (switch_done) done_cnt++;
        end
        check_eq("rp_no_done", done_cnt, 0);
        check_eq("rp_mode_after", mode, 2'd0);
        check_eq("rp_idle_after", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/div_mode_sequencer.md
DIV_MODE_SEQUENCER -- requirements
Module: div_mode_sequencer

Interface
REQ-001 Parameter DWELL_W, default 16: width of the dwell counter and the dwell input.
REQ-002 Parameter TMO_CYC, default 255: maximum cycles spent waiting for a divider edge before a forced switch.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  one-cycle pulse; begins auto-sequencing.
REQ-006 stop  in  1  one-cycle pulse; ends auto-sequencing.
REQ-007 auto_en  in  1  auto-sequence enable, sampled when start is accepted.
REQ-008 dwell  in  DWELL_W  clk cycles to hold each mode in auto-sequencing; 0 is treated as 1.
REQ-009 req_valid  in  1  manual mode-change request.
REQ-010 req_mode  in  2  target mode for a manual request.
REQ-011 req_ready  out  1  high when a manual request can be accepted.
REQ-012 div_out  in  1  divided clock from DIV_CLK_4_MODE.OUT, same clk domain.
REQ-013 mode  out  2  mode select driven to DIV_CLK_4_MODE.mode.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 switch_done  out  1  one-cycle pulse after each mode update.
REQ-016 timeout  out  1  sticky flag; set when a switch was forced.

Function
REQ-017 The FSM SHALL have three states: IDLE, DWELL and PEND, and every output SHALL be registered.
REQ-018 In IDLE, start=1 with auto_en=1 SHALL load the counter with max(dwell,1) and go to DWELL; start with auto_en=0 SHALL be ignored.
REQ-019 In IDLE, req_ready=1; req_valid&req_ready SHALL latch req_mode as target and go to PEND; in other states, req_ready=0.
REQ-020 In IDLE, simultaneous start and req_valid SHALL accept the manual request and ignore start.
REQ-021 In DWELL, the counter SHALL decrement by 1 each cycle.
REQ-022 On the cycle the counter reads 1, target SHALL become (mode+1) mod 4 (3 wraps to 0) and the FSM SHALL go to PEND.
REQ-023 In PEND, a rising edge of div_out SHALL be div_out=1 with the registered previous sample div_q=0.
REQ-024 On the clock edge where a rising edge is detected, mode SHALL take target, and switch_done SHALL be 1 for exactly the following cycle.
REQ-025 If no rising edge of div_out occurs within TMO_CYC cycles in PEND, the switch SHALL be forced in the same way and timeout SHALL be set.
REQ-026 If target equals the current mode, the switch SHALL still wait for the edge, and switch_done SHALL still pulse.
REQ-027 After a switch, an auto session SHALL reload the counter and go to DWELL, and a manual request SHALL go to IDLE.
REQ-028 stop in DWELL SHALL go to IDLE next cycle with mode unchanged.
REQ-029 stop in PEND SHALL let the pending switch complete and then go to IDLE.
REQ-030 Simultaneous start and stop SHALL act as stop.
REQ-031 Changes to dwell during DWELL SHALL take effect only at the next reload.
REQ-032 timeout SHALL clear only on reset or on an accepted start.

Reset
REQ-033 Asserting rst_n=0 SHALL immediately force state=IDLE, mode=0, busy=0, req_ready=1, switch_done=0, timeout=0, counter=0 and div_q=0.
REQ-034 Reset mid-PEND SHALL discard the pending target without producing a switch_done pulse.
REQ-035 After release, the first possible edge detection SHALL use div_q=0.

Structure
REQ-036 The state encoding, the 2-bit mode width constant and the MODE_MAX=3 constant SHALL live in a shared package, div_ctrl_pkg.
REQ-037 The rising-edge detect and timeout counter SHALL be one sub-module, div_edge_wait, with inputs arm and div_out and outputs fire and forced.

Verification
REQ-038 Auto run: dwell=100, start with auto_en=1 -> mode steps 0,1,2,3,0; each step waits at least 100 cycles plus the edge wait; switch_done pulses 4 times.
REQ-039 Edge alignment: manual req_mode=2 while div_out is held low for 10 cycles -> mode changes exactly on the clock edge where div_out rises; timeout=0.
REQ-040 Timeout: TMO_CYC=255, div_out held at 0, req_mode=3 -> mode=3 after 255 cycles in PEND; timeout=1 until the next start.
REQ-041 Stop handling: stop at counter=50 in DWELL -> IDLE next cycle, mode unchanged; stop in PEND -> one switch_done pulse, then IDLE.
REQ-042 Reset mid-PEND: rst_n low in PEND -> mode=0 and busy=0 immediately; no switch_done pulse after release.
REQ-043 Boundaries: dwell=0 behaves as dwell=1; start and stop in the same cycle -> remains IDLE; req_valid while busy -> not accepted, req_ready=0.
